// File: rtl/heading_step_ctrl.sv
// rtl/heading_step_ctrl.sv - keyboard-driven heading/run control stepping a position on a wrapping grid
module heading_step_ctrl #(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int X_MAX    = 159,
    parameter int Y_MAX    = 119,
    parameter int X_INIT   = 80,
    parameter int Y_INIT   = 60,
    parameter int TICK_DIV = 833333,
    parameter int CNT_W    = 20
) (
    input  logic           CLOCK_50,
    input  logic           Resetn,
    input  logic           signalStraight,
    input  logic           signalLeft,
    input  logic           signalRight,
    input  logic           enable,
    output logic [X_W-1:0] pos_x,
    output logic [Y_W-1:0] pos_y,
    output logic [1:0]     heading,
    output logic           moving,
    output logic           step_pulse
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t           state, next_state;
    logic             s_q, l_q, r_q;
    logic             s_edge, l_edge, r_edge;
    logic [CNT_W-1:0] cnt;
    logic             tick;
    logic             do_step;

    // edge registers clear on reset, so a level already high right after reset is a command
    assign s_edge  = signalStraight & ~s_q;
    assign l_edge  = signalLeft     & ~l_q;
    assign r_edge  = signalRight    & ~r_q;
    assign tick    = enable & (cnt == CNT_W'(TICK_DIV - 1));
    assign do_step = tick & (state == RUN);
    assign moving  = (state == RUN);

    always_comb begin
        next_state = state;
        if (s_edge) begin
            next_state = (state == IDLE) ? RUN : IDLE;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) begin
            state <= IDLE;
            s_q   <= 1'b0;
            l_q   <= 1'b0;
            r_q   <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= next_state;
            s_q   <= signalStraight;
            l_q   <= signalLeft;
            r_q   <= signalRight;
            if (!enable || tick) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // simultaneous L and R cancel
    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) begin
            heading <= 2'd1;
        end else if (l_edge && !r_edge) begin
            heading <= heading - 2'd1;
        end else if (r_edge && !l_edge) begin
            heading <= heading + 2'd1;
        end
    end

    // a step uses the heading held before this edge, not one turned on the same edge
    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) begin
            pos_x      <= X_W'(X_INIT);
            pos_y      <= Y_W'(Y_INIT);
            step_pulse <= 1'b0;
        end else begin
            step_pulse <= do_step;
            if (do_step) begin
                case (heading)
                    2'd0: pos_y <= (pos_y == '0) ? Y_W'(Y_MAX) : pos_y - 1'b1;
                    2'd1: pos_x <= (pos_x == X_W'(X_MAX)) ? '0 : pos_x + 1'b1;
                    2'd2: pos_y <= (pos_y == Y_W'(Y_MAX)) ? '0 : pos_y + 1'b1;
                    default: pos_x <= (pos_x == '0) ? X_W'(X_MAX) : pos_x - 1'b1;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_heading_step_ctrl.sv
// tb/tb_heading_step_ctrl.sv - scoreboard bench for heading_step_ctrl on a small 8x6 grid
module tb_heading_step_ctrl;

    localparam int XMAX = 7;
    localparam int YMAX = 5;
    localparam int DIV  = 4;

    logic       CLOCK_50 = 1'b0;
    logic       Resetn = 1'b0;
    logic       s = 1'b0, l = 1'b0, r = 1'b0, en = 1'b0;
    logic [2:0] pos_x;
    logic [2:0] pos_y;
    logic [1:0] heading;
    logic       moving, step_pulse;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int cyc;
        int x;
        int y;
    } step_t;
    step_t exp_q[$];

    int cyc = 0;
    int m_x, m_y, m_h, m_cnt;
    bit m_run, m_sq, m_lq, m_rq;

    heading_step_ctrl #(
        .X_W(3), .Y_W(3), .X_MAX(XMAX), .Y_MAX(YMAX),
        .X_INIT(3), .Y_INIT(2), .TICK_DIV(DIV), .CNT_W(3)
    ) dut (
        .CLOCK_50(CLOCK_50), .Resetn(Resetn),
        .signalStraight(s), .signalLeft(l), .signalRight(r), .enable(en),
        .pos_x(pos_x), .pos_y(pos_y), .heading(heading),
        .moving(moving), .step_pulse(step_pulse)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // reference model, advanced on each active edge from the inputs held across it
    always @(posedge CLOCK_50) begin
        bit se, le, re, tk;
        cyc++;
        if (!Resetn) begin
            m_x = 3; m_y = 2; m_h = 1; m_cnt = 0;
            m_run = 0; m_sq = 0; m_lq = 0; m_rq = 0;
        end else begin
            se = s && !m_sq;
            le = l && !m_lq;
            re = r && !m_rq;
            tk = en && (m_cnt == DIV - 1);
            if (tk && m_run) begin
                case (m_h)
                    0: m_y = (m_y + YMAX) % (YMAX + 1);
                    1: m_x = (m_x + 1) % (XMAX + 1);
                    2: m_y = (m_y + 1) % (YMAX + 1);
                    default: m_x = (m_x + XMAX) % (XMAX + 1);
                endcase
                exp_q.push_back('{cyc: cyc, x: m_x, y: m_y});
            end
            if (le && !re) m_h = (m_h + 3) % 4;
            if (re && !le) m_h = (m_h + 1) % 4;
            if (se) m_run = !m_run;
            m_cnt = en ? (m_cnt + 1) % DIV : 0;
            m_sq = s; m_lq = l; m_rq = r;
        end
    end

    always @(negedge CLOCK_50) begin
        bit due;
        step_t e;
        if (cyc > 0) begin
            due = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
            if (step_pulse !== 1'b0 || due) check("step_pulse", step_pulse, due);
            if (due) begin
                e = exp_q.pop_front();
                check("step_x", pos_x, e.x);
                check("step_y", pos_y, e.y);
            end
            if (heading !== m_h[1:0]) check("heading_track", heading, m_h);
            if (moving !== m_run) check("moving_track", moving, m_run);
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic wait_pulses(input int n, input string tag);
        int seen = 0;
        for (int i = 0; i < 200 && seen < n; i++) begin
            @(negedge CLOCK_50);
            if (step_pulse) seen++;
        end
        check({tag, "_pulses_seen"}, seen, n);
    endtask

    initial begin
        int h0, x0, y0, gap;
        cycles(2);
        check("rst_x", pos_x, 3);
        check("rst_y", pos_y, 2);
        check("rst_heading", heading, 1);
        check("rst_moving", moving, 0);
        check("rst_pulse", step_pulse, 0);

        Resetn = 1; s = 1; en = 1;
        cycles(1);
        check("start_moving", moving, 1);
        wait_pulses(5, "east_run");
        check("east_wrap_x", pos_x, 0);
        check("east_wrap_y", pos_y, 2);

        cycles(20);
        check("held_s_moving", moving, 1);
        s = 0; cycles(2); s = 1; cycles(1);
        check("stop_moving", moving, 0);
        cycles(12);

        s = 0; cycles(1); s = 1; cycles(1);
        check("restart_moving", moving, 1);
        l = 1; cycles(1); l = 0;
        check("left_heading", heading, 0);
        wait_pulses(3, "north_run");
        check("north_wrap_y", pos_y, 5);

        h0 = heading;
        l = 1; r = 1; cycles(1); l = 0; r = 0;
        check("lr_cancel_heading", heading, h0);
        check("lr_cancel_moving", moving, 1);

        wait_pulses(1, "align");
        x0 = pos_x; y0 = pos_y;
        cycles(3);
        r = 1; cycles(1); r = 0;
        check("turn_tick_pulse", step_pulse, 1);
        check("turn_tick_old_y", pos_y, (y0 + YMAX) % (YMAX + 1));
        check("turn_tick_old_x", pos_x, x0);
        check("turn_tick_heading", heading, 1);
        wait_pulses(1, "after_turn");
        check("after_turn_x", pos_x, (x0 + 1) % (XMAX + 1));

        en = 0; cycles(10);
        en = 1;
        gap = 0;
        for (int i = 1; i <= 10 && gap == 0; i++) begin
            @(negedge CLOCK_50);
            if (step_pulse) gap = i;
        end
        check("reenable_gap", gap, 4);

        cycles(2);
        Resetn = 0; s = 0; cycles(1);
        check("midrst_x", pos_x, 3);
        check("midrst_y", pos_y, 2);
        check("midrst_heading", heading, 1);
        check("midrst_moving", moving, 0);
        Resetn = 1; cycles(6);
        check("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
